// File: rtl/router_input_buffer.sv
// Per-input-port flit FIFO with XY route compute on the head flit.
// Presents a one-hot request and the head flit to the allocators; pops on grant.
module router_input_buffer #(
    parameter int         data_size = 8,
    parameter int         depth     = 4,
    parameter logic [1:0] cur_x     = 2'd0,
    parameter logic [1:0] cur_y     = 2'd0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [data_size-1:0]       in_data,
    output logic                       in_ready,
    output logic [4:0]                 request,
    output logic [data_size-1:0]       data_o,
    input  logic                       grant,
    output logic [$clog2(depth):0]     count
);

    localparam int PW = $clog2(depth);
    localparam int CW = PW + 1;

    logic [data_size-1:0] mem_q [depth];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic [data_size-1:0] last_q, last_d;

    logic                 push, pop, not_empty;
    logic [data_size-1:0] head;
    logic [1:0]           dx, dy;
    logic [4:0]           route;

    assign not_empty = (count_q != '0);
    assign in_ready  = (count_q != CW'(depth));
    assign push      = in_valid & in_ready;
    assign pop       = grant & not_empty;
    assign head      = mem_q[rd_ptr_q];
    assign dx        = head[data_size-1:data_size-2];
    assign dy        = head[data_size-3:data_size-4];

    // Request bit order matches the allocator: L N E S W.
    always_comb begin
        route = 5'b00000;
        if (dx > cur_x)      route = 5'b00100;
        else if (dx < cur_x) route = 5'b00001;
        else if (dy < cur_y) route = 5'b01000;
        else if (dy > cur_y) route = 5'b00010;
        else                 route = 5'b10000;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        last_d   = last_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            last_d   = head;
        end
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
            for (int i = 0; i < depth; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            last_q   <= last_d;
            if (push) mem_q[wr_ptr_q] <= in_data;
        end
    end

    // When empty, data_o keeps showing the most recently popped flit.
    assign request = not_empty ? route : 5'b00000;
    assign data_o  = not_empty ? head : last_q;
    assign count   = count_q;

endmodule

// File: tb/tb_router_input_buffer.sv
// Randomized and directed bench for router_input_buffer at (1,1), depth 4, 8-bit flits.
// A queue-based model predicts every output; a negedge process compares each cycle.
module tb_router_input_buffer;

    localparam int         DS = 8;
    localparam int         DP = 4;
    localparam logic [1:0] CX = 2'd1;
    localparam logic [1:0] CY = 2'd1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [DS-1:0] in_data = '0;
    logic          in_ready;
    logic [4:0]    request;
    logic [DS-1:0] data_o;
    logic          grant = 1'b0;
    logic [2:0]    count;

    int n_vec  = 0;
    int n_fail = 0;

    logic [DS-1:0] mq[$];
    logic [DS-1:0] m_last = '0;

    router_input_buffer #(.data_size(DS), .depth(DP), .cur_x(CX), .cur_y(CY)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .request(request), .data_o(data_o),
        .grant(grant), .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] xy_route(input logic [DS-1:0] f);
        logic [1:0] x, y;
        x = f[7:6];
        y = f[5:4];
        if (x > CX)      return 5'b00100;
        else if (x < CX) return 5'b00001;
        else if (y < CY) return 5'b01000;
        else if (y > CY) return 5'b00010;
        else             return 5'b10000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour: a bounded FIFO of flits plus the last popped flit.
    always @(negedge rst_n) begin
        mq.delete();
        m_last = '0;
    end

    always @(posedge clk) begin
        if (rst_n) begin
            logic do_push, do_pop;
            do_push = in_valid && (mq.size() < DP);
            do_pop  = grant && (mq.size() != 0);
            if (do_pop) m_last = mq.pop_front();
            if (do_push) mq.push_back(in_data);
        end
    end

    always @(negedge clk) begin
        check("count", 32'(count), 32'(mq.size()));
        check("in_ready", 32'(in_ready), 32'(mq.size() < DP));
        check("request", 32'(request), (mq.size() == 0) ? 32'd0 : 32'(xy_route(mq[0])));
        check("data_o", 32'(data_o), (mq.size() == 0) ? 32'(m_last) : 32'(mq[0]));
    end

    task automatic cycle(input logic v, input logic [DS-1:0] d, input logic g);
        in_valid = v;
        in_data  = d;
        grant    = g;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 16 && count != 0; i++) cycle(1'b0, '0, 1'b1);
        check("drain_empty", 32'(count), 32'd0);
    endtask

    logic [DS-1:0] route_flits [5];
    logic [4:0]    route_exp   [5];

    initial begin
        route_flits = '{8'hC0, 8'h00, 8'h40, 8'h60, 8'h50};
        route_exp   = '{5'b00100, 5'b00001, 5'b01000, 5'b00010, 5'b10000};

        #2;
        check("reset_count", 32'(count), 32'd0);
        check("reset_ready", 32'(in_ready), 32'd1);
        check("reset_data", 32'(data_o), 32'd0);
        #20 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Routing table at router (1,1)
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, route_flits[i], 1'b0);
            check("route_req", 32'(request), 32'(route_exp[i]));
            cycle(1'b0, '0, 1'b1);
        end

        // Fill to full, drop the extra flit, then pop once
        cycle(1'b1, 8'h11, 1'b0);
        cycle(1'b1, 8'h22, 1'b0);
        cycle(1'b1, 8'h33, 1'b0);
        cycle(1'b1, 8'h44, 1'b0);
        check("full_count", 32'(count), 32'd4);
        check("full_ready", 32'(in_ready), 32'd0);
        cycle(1'b1, 8'h55, 1'b0);
        check("drop_count", 32'(count), 32'd4);
        cycle(1'b0, '0, 1'b1);
        check("pop_count", 32'(count), 32'd3);
        check("pop_ready", 32'(in_ready), 32'd1);
        check("pop_data", 32'(data_o), 32'h22);
        drain();

        // Sustained push+pop at occupancy 2
        cycle(1'b1, 8'hA0, 1'b0);
        cycle(1'b1, 8'hA1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 8'(8'hB0 + i), 1'b1);
            check("steady_count", 32'(count), 32'd2);
        end
        drain();

        // Nine flits through the four-entry ring
        cycle(1'b1, 8'h01, 1'b0);
        check("wrap_data", 32'(data_o), 32'h01);
        for (int i = 2; i <= 9; i++) begin
            cycle(1'b1, 8'(i), 1'b1);
            check("wrap_data", 32'(data_o), 32'(i));
        end
        cycle(1'b0, '0, 1'b1);
        check("wrap_empty_req", 32'(request), 32'd0);
        check("wrap_hold_data", 32'(data_o), 32'h09);

        // Grant while empty is ignored; push with grant high while empty is kept
        cycle(1'b0, '0, 1'b1);
        check("spur_count", 32'(count), 32'd0);
        cycle(1'b1, 8'hC5, 1'b1);
        check("empty_push_count", 32'(count), 32'd1);
        check("empty_push_req", 32'(request), 32'(5'b00100));
        check("empty_push_data", 32'(data_o), 32'hC5);
        drain();

        // Asynchronous reset with three flits buffered
        cycle(1'b1, 8'h12, 1'b0);
        cycle(1'b1, 8'h34, 1'b0);
        cycle(1'b1, 8'h56, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("areset_req", 32'(request), 32'd0);
        check("areset_count", 32'(count), 32'd0);
        check("areset_ready", 32'(in_ready), 32'd1);
        check("areset_data", 32'(data_o), 32'd0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle(1'b1, 8'h7F, 1'b0);
        check("post_reset_count", 32'(count), 32'd1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                  ($urandom_range(0, 2) != 0));
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
